// File: rtl/sample_frame_packer.sv
// rtl/sample_frame_packer.sv - packs a serial signed sample stream into 8-lane frames for the adder tree
module sample_frame_packer #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              rstn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] out_lane0,
    output logic [DATA_W-1:0] out_lane1,
    output logic [DATA_W-1:0] out_lane2,
    output logic [DATA_W-1:0] out_lane3,
    output logic [DATA_W-1:0] out_lane4,
    output logic [DATA_W-1:0] out_lane5,
    output logic [DATA_W-1:0] out_lane6,
    output logic [DATA_W-1:0] out_lane7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_fill,
    output logic [15:0]       frame_cnt
);

    logic [DATA_W-1:0] collect [0:6];
    logic [DATA_W-1:0] lanes   [0:7];
    logic [2:0]        idx;
    logic              slot_free;
    logic              flush_pend;
    logic              accept;
    logic              complete;
    logic              flush_xfer;

    assign slot_free  = ~out_valid | out_ready;
    assign flush_pend = flush & (idx != 3'd0);
    // Blocking input during a pending flush keeps the flush frame and new samples apart.
    assign in_ready   = rstn & ~flush_pend & ((idx != 3'd7) | slot_free);
    assign accept     = in_valid & in_ready;
    assign complete   = accept & (idx == 3'd7);
    assign flush_xfer = flush_pend & slot_free;

    always_ff @(posedge clock) begin
        if (!rstn) begin
            idx       <= 3'd0;
            out_valid <= 1'b0;
            out_fill  <= 4'd0;
            frame_cnt <= 16'd0;
            for (int k = 0; k < 7; k++) collect[k] <= '0;
            for (int k = 0; k < 8; k++) lanes[k] <= '0;
        end else begin
            if (accept && !complete) begin
                for (int k = 0; k < 7; k++) begin
                    if (idx == 3'(k)) collect[k] <= in_data;
                end
                idx <= idx + 3'd1;
            end

            if (complete) begin
                for (int k = 0; k < 7; k++) lanes[k] <= collect[k];
                lanes[7]  <= in_data;
                out_fill  <= 4'd8;
                out_valid <= 1'b1;
                idx       <= 3'd0;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (flush_xfer) begin
                // Stale collect entries beyond idx are zeroed on the way out.
                for (int k = 0; k < 8; k++) begin
                    if (k < 7 && 3'(k) < idx) lanes[k] <= collect[k % 7];
                    else                      lanes[k] <= '0;
                end
                out_fill  <= {1'b0, idx};
                out_valid <= 1'b1;
                idx       <= 3'd0;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_lane0 = lanes[0];
    assign out_lane1 = lanes[1];
    assign out_lane2 = lanes[2];
    assign out_lane3 = lanes[3];
    assign out_lane4 = lanes[4];
    assign out_lane5 = lanes[5];
    assign out_lane6 = lanes[6];
    assign out_lane7 = lanes[7];

endmodule

// File: tb/tb_sample_frame_packer.sv
// tb/tb_sample_frame_packer.sv - randomized and directed checks of sample_frame_packer against a queue model
module tb_sample_frame_packer;

    logic        clock = 1'b0;
    logic        rstn;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [7:0]  out_lane0, out_lane1, out_lane2, out_lane3;
    logic [7:0]  out_lane4, out_lane5, out_lane6, out_lane7;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_fill;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    // Model: samples awaiting a frame, plus the frame currently offered downstream.
    logic [7:0]  q[$];
    logic [7:0]  m_lanes[8];
    logic        m_valid;
    logic [3:0]  m_fill;
    logic [15:0] m_cnt;
    logic        chk_lanes;

    logic [7:0]  obs_lanes[8];

    sample_frame_packer #(.DATA_W(8)) dut (
        .clock(clock), .rstn(rstn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_lane0(out_lane0), .out_lane1(out_lane1), .out_lane2(out_lane2), .out_lane3(out_lane3),
        .out_lane4(out_lane4), .out_lane5(out_lane5), .out_lane6(out_lane6), .out_lane7(out_lane7),
        .out_valid(out_valid), .out_ready(out_ready), .out_fill(out_fill), .frame_cnt(frame_cnt)
    );

    always #5 clock = ~clock;

    always_comb begin
        obs_lanes[0] = out_lane0; obs_lanes[1] = out_lane1;
        obs_lanes[2] = out_lane2; obs_lanes[3] = out_lane3;
        obs_lanes[4] = out_lane4; obs_lanes[5] = out_lane5;
        obs_lanes[6] = out_lane6; obs_lanes[7] = out_lane7;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic iv, input logic [7:0] d, input logic fl, input logic ordy);
        logic exp_rdy;
        logic slot;
        logic load;
        @(negedge clock);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        #1;
        exp_rdy = rstn && !(fl && q.size() != 0) && (q.size() != 7 || !m_valid || ordy);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        slot = !m_valid || ordy;
        load = 1'b0;
        chk_lanes = 1'b0;
        if (!rstn) begin
            q.delete();
            for (int k = 0; k < 8; k++) m_lanes[k] = 8'd0;
            m_valid = 1'b0;
            m_fill = 4'd0;
            m_cnt = 16'd0;
            chk_lanes = 1'b1;
        end else if (iv && exp_rdy) begin
            q.push_back(d);
            if (q.size() == 8) begin
                for (int k = 0; k < 8; k++) m_lanes[k] = q[k];
                m_fill = 4'd8;
                load = 1'b1;
                q.delete();
            end
        end else if (fl && q.size() > 0 && slot) begin
            for (int k = 0; k < 8; k++) m_lanes[k] = (k < q.size()) ? q[k] : 8'd0;
            m_fill = 4'(q.size());
            load = 1'b1;
            q.delete();
        end
        if (load) begin
            m_valid = 1'b1;
            m_cnt = m_cnt + 16'd1;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
        if (m_valid || chk_lanes) begin
            check("out_fill", {28'd0, out_fill}, {28'd0, m_fill});
            for (int k = 0; k < 8; k++) check($sformatf("lane%0d", k), {24'd0, obs_lanes[k]}, {24'd0, m_lanes[k]});
        end
    endtask

    initial begin
        logic [7:0] ext[4];
        rstn = 1'b0; in_valid = 1'b0; in_data = 8'd0; flush = 1'b0; out_ready = 1'b0;
        m_valid = 1'b0; m_fill = 4'd0; m_cnt = 16'd0; chk_lanes = 1'b0;
        for (int k = 0; k < 8; k++) m_lanes[k] = 8'd0;

        step(1'b1, 8'd3, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check("reset_fill", {28'd0, out_fill}, 32'd0);
        rstn = 1'b1;

        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) check("ramp_lane", {24'd0, obs_lanes[k]}, 32'(k + 1));
        check("ramp_cnt", {16'd0, frame_cnt}, 32'd1);
        step(1'b0, 8'd0, 1'b0, 1'b1);

        ext[0] = 8'h80; ext[1] = 8'h7F; ext[2] = 8'hFF; ext[3] = 8'h00;
        for (int i = 0; i < 16; i++) step(1'b1, (i < 4) ? ext[i] : 8'($urandom), 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        check("bp_hold_lane0", {24'd0, out_lane0}, {24'd0, m_lanes[0]});
        step(1'b1, 8'h47, 1'b0, 1'b1);
        check("bp_release_lane7", {24'd0, out_lane7}, 32'h47);
        step(1'b0, 8'd0, 1'b0, 1'b1);

        step(1'b1, 8'd5, 1'b0, 1'b1);
        step(1'b1, 8'hFA, 1'b0, 1'b1);
        step(1'b1, 8'd7, 1'b0, 1'b1);
        step(1'b1, 8'd99, 1'b1, 1'b1);
        check("flush_fill", {28'd0, out_fill}, 32'd3);
        check("flush_lane1", {24'd0, out_lane1}, 32'hFA);
        check("flush_lane3", {24'd0, out_lane3}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b1, 1'b1);

        for (int i = 0; i < 13; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        rstn = 1'b0;
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check("midreset_cnt", {16'd0, frame_cnt}, 32'd0);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
        check("post_reset_lane0", {24'd0, out_lane0}, 32'h10);
        step(1'b0, 8'd0, 1'b0, 1'b1);

        @(negedge clock);
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        m_cnt = 16'hFFFF;
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1);
        check("wrap_cnt", {16'd0, frame_cnt}, 32'd0);

        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 16) == 0, ($urandom % 3) != 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
